seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clk cycles each digit is lit (>=1).
REQ-003 SHALL have parameter BLANK_CYCLES, default 8, clk cycles of anti-ghost gap between digits (>=1).
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port enable  in  1  scan enable.
REQ-007 SHALL have port load_valid  in  1  new display value offered.
REQ-008 SHALL have port load_data  in  4*NUM_DIGITS  BCD digits; nibble k is digit k, with digit 0 least significant.
REQ-009 SHALL have port load_ready  out  1  shadow register free.
REQ-010 SHALL have port seg  out  7  segments, active-high, seg[0]=a .. seg[6]=g.
REQ-011 SHALL have port an  out  NUM_DIGITS  one-hot digit enable, active-high.
REQ-012 SHALL have port frame_done  out  1  one-cycle pulse at end of each full scan.

Function
REQ-013 SHALL implement an FSM with states IDLE, SCAN and GAP.
REQ-014 IDLE SHALL drive an=0 and seg=0, and SHALL go to SCAN with digit index 0 on the cycle after enable=1.
REQ-015 SCAN SHALL drive an[idx]=1 and seg=decode(display[idx]) for exactly REFRESH_DIV cycles, then go to GAP.
REQ-016 GAP SHALL drive an=0 and seg=0 for exactly BLANK_CYCLES cycles, then go to SCAN with idx=(idx+1) mod NUM_DIGITS.
REQ-017 The frame period SHALL be NUM_DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles.
REQ-018 frame_done SHALL pulse for one cycle, coincident with the GAP-to-SCAN transition from idx=NUM_DIGITS-1.
REQ-019 seg, an and frame_done SHALL be registered, updated on the same edge as the state, with no combinational input-to-output path.
REQ-020 A BCD nibble above 9 SHALL display blank (seg=0).
REQ-021 Handshake: load_ready SHALL equal !pending, and on load_valid&&load_ready the shadow SHALL take load_data and pending SHALL be set.
REQ-022 Shadow-to-display transfer SHALL occur only on the frame_done cycle, or on the next cycle while in IDLE, and SHALL clear pending.
REQ-023 Display contents SHALL never change mid-frame (no tearing).
REQ-024 enable=0 in SCAN or GAP SHALL force IDLE on the next edge, reset idx and the divider to 0, emit no frame_done, and preserve display, shadow and pending.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately force state IDLE, seg=0, an=0, frame_done=0, load_ready=1, and clear display, shadow, pending, idx and the divider.
REQ-026 Reset assertion mid-frame SHALL abort the frame without a frame_done pulse.
REQ-027 Reset release SHALL take effect synchronously to clk.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN SHALL, when defined, blank digit k>0 (an[k]=0, seg=0 during its SCAN slot, timing unchanged) whenever digits NUM_DIGITS-1..k are all zero.
REQ-029 Digit 0 SHALL never be blanked by this feature.
REQ-030 Without LEADING_ZERO_BLANK_EN, every digit SHALL display as decoded, including leading zeros.

Structure
REQ-031 Package seven_seg_pkg SHALL hold the state enum, the SEG_BLANK constant (7'b0000000) and the parameter default constants.
REQ-032 BCD-to-segment decoding SHALL use exactly one instance of sub-module seven_segment_decoder, fed from an idx-selected mux.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2)
REQ-033 Reset check: rst_n=0 -> seg=0, an=0, load_ready=1; after release with enable=0, outputs stay 0 for 20 cycles.
REQ-034 Basic scan: load 0x1234 in IDLE, then enable=1 -> an=0001 with seg=7'b1100110 for 4 cycles, then an=0000 for 2 cycles, then an=0010 with seg=7'b1001111; frame_done fires every 24 cycles.
REQ-035 Mid-frame load: load 0x5678 during scan -> load_ready=0 and the displayed value stays 1234 until frame_done; the next digit-0 slot shows 7'b1111111 and load_ready returns to 1.
REQ-036 Enable drop: enable=0 during the digit-2 slot -> an=0 and seg=0 next cycle with no frame_done; re-enable restarts at an=0001.
REQ-037 Reset mid-frame: rst_n=0 at cycle 10 of a frame with pending=1 -> outputs 0 immediately; after release the display reads 0000 and load_ready=1.
REQ-038 Leading-zero blanking: load 0x0070 -> with LEADING_ZERO_BLANK_EN, an[3] and an[2] are never asserted while digit 1 shows 7'b0000111 and digit 0 shows 7'b0111111; without the macro, digit 3 shows 7'b0111111.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        GAP  = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam int NUM_DIGITS_DEFAULT   = 4;
    localparam int REFRESH_DIV_DEFAULT  = 50000;
    localparam int BLANK_CYCLES_DEFAULT = 8;

endpackage

// File: rtl/seven_segment_decoder.sv
// BCD digit to active-high segment pattern (bit0=a .. bit6=g); non-BCD codes show blank.
module seven_segment_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pure lookup of the segment pattern for one digit.
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0: seg_o = 7'b0111111;
            4'd1: seg_o = 7'b0000110;
            4'd2: seg_o = 7'b1011011;
            4'd3: seg_o = 7'b1001111;
            4'd4: seg_o = 7'b1100110;
            4'd5: seg_o = 7'b1101101;
            4'd6: seg_o = 7'b1111101;
            4'd7: seg_o = 7'b0000111;
            4'd8: seg_o = 7'b1111111;
            4'd9: seg_o = 7'b1101111;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a shadow-register load handshake.
// New values are only moved into the display at a frame boundary (or while idle),
// so a frame never mixes old and new digits.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
//
//   state | meaning
//   IDLE  | scan stopped, all digits dark
//   SCAN  | digit idx lit for REFRESH_DIV cycles
//   GAP   | all digits dark for BLANK_CYCLES cycles before the next digit
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = NUM_DIGITS_DEFAULT,
    parameter int REFRESH_DIV  = REFRESH_DIV_DEFAULT,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] REF_LOAD = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    scan_state_e                 state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][3:0]  display_q, display_d;
    logic [NUM_DIGITS-1:0][3:0]  shadow_q, shadow_d;
    logic                        pending_q, pending_d;
    logic                        frame_done_q, frame_done_d;
    logic [6:0]                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0]       an_q, an_d;
    logic [NUM_DIGITS-1:0]       blank_mask;
    logic [3:0]                  bcd_sel;
    logic [6:0]                  dec_seg;

    // Decoder sees the digit that will be lit after this edge, so seg can be registered.
    assign bcd_sel = display_d[idx_d];

    seven_segment_decoder u_decoder (
        .bcd_i (bcd_sel),
        .seg_o (dec_seg)
    );

    // Next-state, dwell timer, handshake and display transfer.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        display_d    = display_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;

        if (load_valid && !pending_q) begin
            shadow_d  = load_data;
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    cnt_d   = REF_LOAD;
                end
            end
            SCAN: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = BLK_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = SCAN;
                    cnt_d   = REF_LOAD;
                    if (idx_q == IDX_LAST) begin
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // Pending and accept are mutually exclusive, so this never drops a fresh load.
        if (pending_q && (frame_done_d || state_q == IDLE)) begin
            display_d = shadow_q;
            pending_d = 1'b0;
        end
    end

    // Leading-zero mask: digit k dark when it and every more significant digit are zero.
    always_comb begin
        logic lz;
        blank_mask = '0;
        lz         = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            lz            = lz && (display_d[k] == 4'd0);
            blank_mask[k] = lz;
        end
`else
        lz         = 1'b0;
        blank_mask = {NUM_DIGITS{lz}};
`endif
    end

    // Output values matching the state being entered on this edge.
    always_comb begin
        an_d  = '0;
        seg_d = SEG_BLANK;
        if (state_d == SCAN && !blank_mask[idx_d]) begin
            an_d[idx_d] = 1'b1;
            seg_d       = dec_seg;
        end
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            display_q    <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            display_q    <= display_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign load_ready = !pending_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (4 digits, 4-cycle slot, 2-cycle gap).
// Expected outputs come from a frame-time model: position in frame = cycles since
// scan start mod frame length, from which digit and lit/dark are derived arithmetically.
module tb_seven_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int R     = 4;
    localparam int B     = 2;
    localparam int SLOT  = R + B;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    bit          m_run;
    int          m_t;
    logic [15:0] m_disp;
    logic [15:0] m_shad;
    bit          m_pend;
    bit          m_fd;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic bit digit_dark(input logic [15:0] disp, input int d);
`ifdef LEADING_ZERO_BLANK_EN
        return (d > 0) && ((disp >> (4 * d)) == 16'd0);
`else
        return (d < 0) && (disp == 16'd0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_t    = 0;
        m_disp = '0;
        m_shad = '0;
        m_pend = 1'b0;
        m_fd   = 1'b0;
    endtask

    task automatic check_outputs();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic [3:0] dig;
        int pos, d;
        exp_an  = '0;
        exp_seg = '0;
        if (m_run) begin
            pos = m_t % FRAME;
            d   = pos / SLOT;
            dig = 4'(m_disp >> (4 * d));
            if ((pos % SLOT) < R && !digit_dark(m_disp, d)) begin
                exp_an  = 4'(1 << d);
                exp_seg = seg_of(dig);
            end
        end
        chk("an", 32'(an), 32'(exp_an));
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("load_ready", 32'(load_ready), 32'(!m_pend));
    endtask

    task automatic step(input bit en, input bit lv, input logic [15:0] ld);
        bit acc;
        enable     = en;
        load_valid = lv;
        load_data  = ld;
        @(posedge clk);
        acc  = lv && !m_pend;
        m_fd = 1'b0;
        if (!m_run) begin
            if (m_pend) begin
                m_disp = m_shad;
                m_pend = 1'b0;
            end
            if (en) begin
                m_run = 1'b1;
                m_t   = 0;
            end
        end else if (!en) begin
            m_run = 1'b0;
        end else begin
            m_t++;
            if (m_t % FRAME == 0) begin
                m_fd = 1'b1;
                if (m_pend) begin
                    m_disp = m_shad;
                    m_pend = 1'b0;
                end
            end
        end
        if (acc) begin
            m_shad = ld;
            m_pend = 1'b1;
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] rd;
        rst_n      = 1'b0;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        model_reset();
        #2;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Outputs stay dark with enable low.
        repeat (20) step(1'b0, 1'b0, 16'h0);

        // Basic scan of 0x1234 loaded while idle.
        step(1'b0, 1'b1, 16'h1234);
        step(1'b0, 1'b0, 16'h0);
        chk("ready_after_idle_load", 32'(load_ready), 32'd1);
        step(1'b1, 1'b0, 16'h0);
        chk("first_an", 32'(an), 32'b0001);
        chk("first_seg", 32'(seg), 32'b1100110);
        repeat (5) step(1'b1, 1'b0, 16'h0);
        chk("gap_an", 32'(an), 32'd0);
        step(1'b1, 1'b0, 16'h0);
        chk("digit1_an", 32'(an), 32'b0010);
        chk("digit1_seg", 32'(seg), 32'b1001111);

        // Mid-frame load must wait for the frame boundary.
        repeat (10) step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h5678);
        chk("ready_low_pending", 32'(load_ready), 32'd0);
        repeat (7) step(1'b1, 1'b0, 16'h0);
        chk("fd_at_boundary", 32'(frame_done), 32'd1);
        chk("new_digit0_seg", 32'(seg), 32'b1111111);
        chk("ready_back", 32'(load_ready), 32'd1);
        repeat (30) step(1'b1, 1'b0, 16'h0);

        // Enable drop inside the digit-2 slot, then restart.
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        repeat (13) step(1'b1, 1'b0, 16'h0);
        chk("digit2_an", 32'(an), 32'b0100);
        step(1'b0, 1'b0, 16'h0);
        chk("drop_an", 32'(an), 32'd0);
        chk("drop_fd", 32'(frame_done), 32'd0);
        repeat (3) step(1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        chk("restart_an", 32'(an), 32'b0001);

        // Reset at cycle 10 of a frame with a load pending.
        repeat (5) step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h9999);
        repeat (4) step(1'b1, 1'b0, 16'h0);
        do_reset();
        chk("rst_ready", 32'(load_ready), 32'd1);
        step(1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        chk("post_rst_seg", 32'(seg), 32'b0111111);
        repeat (30) step(1'b1, 1'b0, 16'h0);

        // Leading-zero behaviour on 0x0070.
        step(1'b1, 1'b1, 16'h0070);
        repeat (60) step(1'b1, 1'b0, 16'h0);

        // Randomized traffic with zero-biased nibbles and occasional resets.
        for (int i = 0; i < 800; i++) begin
            rd = '0;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 1) rd[4*k +: 4] = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 199) == 0) do_reset();
            step($urandom_range(0, 19) != 0, $urandom_range(0, 3) == 0, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
